// File: rtl/aes128_key_expansion.sv
// rtl/aes128_key_expansion.sv - iterative AES-128 key schedule, one round key per clock
// Loads the cipher key as round key 0, then steps through round keys 1..10 and holds the last.

module aes128_sbox (
  input  logic [7:0] a,
  output logic [7:0] q
);
  always_comb begin
    q = 8'h00;
    case (a)
      8'h00: q = 8'h63; 8'h01: q = 8'h7c; 8'h02: q = 8'h77; 8'h03: q = 8'h7b; 8'h04: q = 8'hf2; 8'h05: q = 8'h6b; 8'h06: q = 8'h6f; 8'h07: q = 8'hc5;
      8'h08: q = 8'h30; 8'h09: q = 8'h01; 8'h0a: q = 8'h67; 8'h0b: q = 8'h2b; 8'h0c: q = 8'hfe; 8'h0d: q = 8'hd7; 8'h0e: q = 8'hab; 8'h0f: q = 8'h76;
      8'h10: q = 8'hca; 8'h11: q = 8'h82; 8'h12: q = 8'hc9; 8'h13: q = 8'h7d; 8'h14: q = 8'hfa; 8'h15: q = 8'h59; 8'h16: q = 8'h47; 8'h17: q = 8'hf0;
      8'h18: q = 8'had; 8'h19: q = 8'hd4; 8'h1a: q = 8'ha2; 8'h1b: q = 8'haf; 8'h1c: q = 8'h9c; 8'h1d: q = 8'ha4; 8'h1e: q = 8'h72; 8'h1f: q = 8'hc0;
      8'h20: q = 8'hb7; 8'h21: q = 8'hfd; 8'h22: q = 8'h93; 8'h23: q = 8'h26; 8'h24: q = 8'h36; 8'h25: q = 8'h3f; 8'h26: q = 8'hf7; 8'h27: q = 8'hcc;
      8'h28: q = 8'h34; 8'h29: q = 8'ha5; 8'h2a: q = 8'he5; 8'h2b: q = 8'hf1; 8'h2c: q = 8'h71; 8'h2d: q = 8'hd8; 8'h2e: q = 8'h31; 8'h2f: q = 8'h15;
      8'h30: q = 8'h04; 8'h31: q = 8'hc7; 8'h32: q = 8'h23; 8'h33: q = 8'hc3; 8'h34: q = 8'h18; 8'h35: q = 8'h96; 8'h36: q = 8'h05; 8'h37: q = 8'h9a;
      8'h38: q = 8'h07; 8'h39: q = 8'h12; 8'h3a: q = 8'h80; 8'h3b: q = 8'he2; 8'h3c: q = 8'heb; 8'h3d: q = 8'h27; 8'h3e: q = 8'hb2; 8'h3f: q = 8'h75;
      8'h40: q = 8'h09; 8'h41: q = 8'h83; 8'h42: q = 8'h2c; 8'h43: q = 8'h1a; 8'h44: q = 8'h1b; 8'h45: q = 8'h6e; 8'h46: q = 8'h5a; 8'h47: q = 8'ha0;
      8'h48: q = 8'h52; 8'h49: q = 8'h3b; 8'h4a: q = 8'hd6; 8'h4b: q = 8'hb3; 8'h4c: q = 8'h29; 8'h4d: q = 8'he3; 8'h4e: q = 8'h2f; 8'h4f: q = 8'h84;
      8'h50: q = 8'h53; 8'h51: q = 8'hd1; 8'h52: q = 8'h00; 8'h53: q = 8'hed; 8'h54: q = 8'h20; 8'h55: q = 8'hfc; 8'h56: q = 8'hb1; 8'h57: q = 8'h5b;
      8'h58: q = 8'h6a; 8'h59: q = 8'hcb; 8'h5a: q = 8'hbe; 8'h5b: q = 8'h39; 8'h5c: q = 8'h4a; 8'h5d: q = 8'h4c; 8'h5e: q = 8'h58; 8'h5f: q = 8'hcf;
      8'h60: q = 8'hd0; 8'h61: q = 8'hef; 8'h62: q = 8'haa; 8'h63: q = 8'hfb; 8'h64: q = 8'h43; 8'h65: q = 8'h4d; 8'h66: q = 8'h33; 8'h67: q = 8'h85;
      8'h68: q = 8'h45; 8'h69: q = 8'hf9; 8'h6a: q = 8'h02; 8'h6b: q = 8'h7f; 8'h6c: q = 8'h50; 8'h6d: q = 8'h3c; 8'h6e: q = 8'h9f; 8'h6f: q = 8'ha8;
      8'h70: q = 8'h51; 8'h71: q = 8'ha3; 8'h72: q = 8'h40; 8'h73: q = 8'h8f; 8'h74: q = 8'h92; 8'h75: q = 8'h9d; 8'h76: q = 8'h38; 8'h77: q = 8'hf5;
      8'h78: q = 8'hbc; 8'h79: q = 8'hb6; 8'h7a: q = 8'hda; 8'h7b: q = 8'h21; 8'h7c: q = 8'h10; 8'h7d: q = 8'hff; 8'h7e: q = 8'hf3; 8'h7f: q = 8'hd2;
      8'h80: q = 8'hcd; 8'h81: q = 8'h0c; 8'h82: q = 8'h13; 8'h83: q = 8'hec; 8'h84: q = 8'h5f; 8'h85: q = 8'h97; 8'h86: q = 8'h44; 8'h87: q = 8'h17;
      8'h88: q = 8'hc4; 8'h89: q = 8'ha7; 8'h8a: q = 8'h7e; 8'h8b: q = 8'h3d; 8'h8c: q = 8'h64; 8'h8d: q = 8'h5d; 8'h8e: q = 8'h19; 8'h8f: q = 8'h73;
      8'h90: q = 8'h60; 8'h91: q = 8'h81; 8'h92: q = 8'h4f; 8'h93: q = 8'hdc; 8'h94: q = 8'h22; 8'h95: q = 8'h2a; 8'h96: q = 8'h90; 8'h97: q = 8'h88;
      8'h98: q = 8'h46; 8'h99: q = 8'hee; 8'h9a: q = 8'hb8; 8'h9b: q = 8'h14; 8'h9c: q = 8'hde; 8'h9d: q = 8'h5e; 8'h9e: q = 8'h0b; 8'h9f: q = 8'hdb;
      8'ha0: q = 8'he0; 8'ha1: q = 8'h32; 8'ha2: q = 8'h3a; 8'ha3: q = 8'h0a; 8'ha4: q = 8'h49; 8'ha5: q = 8'h06; 8'ha6: q = 8'h24; 8'ha7: q = 8'h5c;
      8'ha8: q = 8'hc2; 8'ha9: q = 8'hd3; 8'haa: q = 8'hac; 8'hab: q = 8'h62; 8'hac: q = 8'h91; 8'had: q = 8'h95; 8'hae: q = 8'he4; 8'haf: q = 8'h79;
      8'hb0: q = 8'he7; 8'hb1: q = 8'hc8; 8'hb2: q = 8'h37; 8'hb3: q = 8'h6d; 8'hb4: q = 8'h8d; 8'hb5: q = 8'hd5; 8'hb6: q = 8'h4e; 8'hb7: q = 8'ha9;
      8'hb8: q = 8'h6c; 8'hb9: q = 8'h56; 8'hba: q = 8'hf4; 8'hbb: q = 8'hea; 8'hbc: q = 8'h65; 8'hbd: q = 8'h7a; 8'hbe: q = 8'hae; 8'hbf: q = 8'h08;
      8'hc0: q = 8'hba; 8'hc1: q = 8'h78; 8'hc2: q = 8'h25; 8'hc3: q = 8'h2e; 8'hc4: q = 8'h1c; 8'hc5: q = 8'ha6; 8'hc6: q = 8'hb4; 8'hc7: q = 8'hc6;
      8'hc8: q = 8'he8; 8'hc9: q = 8'hdd; 8'hca: q = 8'h74; 8'hcb: q = 8'h1f; 8'hcc: q = 8'h4b; 8'hcd: q = 8'hbd; 8'hce: q = 8'h8b; 8'hcf: q = 8'h8a;
      8'hd0: q = 8'h70; 8'hd1: q = 8'h3e; 8'hd2: q = 8'hb5; 8'hd3: q = 8'h66; 8'hd4: q = 8'h48; 8'hd5: q = 8'h03; 8'hd6: q = 8'hf6; 8'hd7: q = 8'h0e;
      8'hd8: q = 8'h61; 8'hd9: q = 8'h35; 8'hda: q = 8'h57; 8'hdb: q = 8'hb9; 8'hdc: q = 8'h86; 8'hdd: q = 8'hc1; 8'hde: q = 8'h1d; 8'hdf: q = 8'h9e;
      8'he0: q = 8'he1; 8'he1: q = 8'hf8; 8'he2: q = 8'h98; 8'he3: q = 8'h11; 8'he4: q = 8'h69; 8'he5: q = 8'hd9; 8'he6: q = 8'h8e; 8'he7: q = 8'h94;
      8'he8: q = 8'h9b; 8'he9: q = 8'h1e; 8'hea: q = 8'h87; 8'heb: q = 8'he9; 8'hec: q = 8'hce; 8'hed: q = 8'h55; 8'hee: q = 8'h28; 8'hef: q = 8'hdf;
      8'hf0: q = 8'h8c; 8'hf1: q = 8'ha1; 8'hf2: q = 8'h89; 8'hf3: q = 8'h0d; 8'hf4: q = 8'hbf; 8'hf5: q = 8'he6; 8'hf6: q = 8'h42; 8'hf7: q = 8'h68;
      8'hf8: q = 8'h41; 8'hf9: q = 8'h99; 8'hfa: q = 8'h2d; 8'hfb: q = 8'h0f; 8'hfc: q = 8'hb0; 8'hfd: q = 8'h54; 8'hfe: q = 8'hbb; 8'hff: q = 8'h16;
    endcase
  end
endmodule

module aes128_key_expansion (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start_in,
  input  logic [31:0] key0_in,
  input  logic [31:0] key1_in,
  input  logic [31:0] key2_in,
  input  logic [31:0] key3_in,
  output logic [31:0] key0_out,
  output logic [31:0] key1_out,
  output logic [31:0] key2_out,
  output logic [31:0] key3_out,
  output logic [1:0]  state_out
);
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;

  state_t      state;
  logic [3:0]  round_r;
  logic [7:0]  rcon;
  logic [31:0] rot, sub, t, n0, n1, n2, n3;

  // round_r counts completed steps, so the key being built uses Rcon[round_r+1]
  always_comb begin
    rcon = 8'h00;
    case (round_r)
      4'd0: rcon = 8'h01;
      4'd1: rcon = 8'h02;
      4'd2: rcon = 8'h04;
      4'd3: rcon = 8'h08;
      4'd4: rcon = 8'h10;
      4'd5: rcon = 8'h20;
      4'd6: rcon = 8'h40;
      4'd7: rcon = 8'h80;
      4'd8: rcon = 8'h1b;
      4'd9: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign rot = {key3_out[23:0], key3_out[31:24]};

  aes128_sbox u_sbox3 (.a(rot[31:24]), .q(sub[31:24]));
  aes128_sbox u_sbox2 (.a(rot[23:16]), .q(sub[23:16]));
  aes128_sbox u_sbox1 (.a(rot[15:8]),  .q(sub[15:8]));
  aes128_sbox u_sbox0 (.a(rot[7:0]),   .q(sub[7:0]));

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = key0_out ^ t;
  assign n1 = key1_out ^ n0;
  assign n2 = key2_out ^ n1;
  assign n3 = key3_out ^ n2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      round_r  <= 4'd0;
      key0_out <= 32'h0;
      key1_out <= 32'h0;
      key2_out <= 32'h0;
      key3_out <= 32'h0;
    end else begin
      case (state)
        BUSY: begin
          key0_out <= n0;
          key1_out <= n1;
          key2_out <= n2;
          key3_out <= n3;
          round_r  <= round_r + 4'd1;
          if (round_r == 4'd9) state <= DONE;
        end
        default: begin
          if (start_in) begin
            key0_out <= key0_in;
            key1_out <= key1_in;
            key2_out <= key2_in;
            key3_out <= key3_in;
            round_r  <= 4'd0;
            state    <= BUSY;
          end
        end
      endcase
    end
  end

  assign state_out = state;
endmodule

// File: tb/tb_aes128_key_expansion.sv
// tb/tb_aes128_key_expansion.sv - scoreboard bench for the AES-128 key schedule
module tb_aes128_key_expansion;
  logic        CLK, RST, start_in;
  logic [31:0] key0_in, key1_in, key2_in, key3_in;
  logic [31:0] key0_out, key1_out, key2_out, key3_out;
  logic [1:0]  state_out;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [127:0] key;
    logic [1:0]   st;
    logic [3:0]   rnd;
  } exp_t;
  exp_t sb[$];

  localparam logic [127:0] KA [0:10] = '{
    128'h54686174_73206d79_204b756e_67204675,
    128'he232fcf1_91129188_b159e4e6_d679a293,
    128'h56082007_c71ab18f_76435569_a03af7fa,
    128'hd2600de7_157abc68_6339e901_c3031efb,
    128'ha11202c9_b468bea1_d75157a0_1452495b,
    128'hb1293b33_05418592_d210d232_c6429b69,
    128'hbd3dc287_b87c4715_6a6c9527_ac2e0e4e,
    128'hcc96ed16_74eaaa03_1e863f24_b2a8316a,
    128'h8e51ef21_fabb4522_e43d7a06_56954b6c,
    128'hbfe2bf90_4559fab2_a16480b4_f7f1cbd8,
    128'h28fddef8_6da4244a_ccc0a4fe_3b316f26};

  localparam logic [127:0] KF [0:10] = '{
    128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
    128'ha0fafe17_88542cb1_23a33939_2a6c7605,
    128'hf2c295f2_7a96b943_5935807a_7359f67f,
    128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
    128'hef44a541_a8525b7f_b671253b_db0bad00,
    128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
    128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
    128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
    128'head27321_b58dbad2_312bf560_7f8d292f,
    128'hac7766f3_19fadc21_28d12941_575c006e,
    128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6};

  aes128_key_expansion dut (
    .CLK(CLK), .RST(RST), .start_in(start_in),
    .key0_in(key0_in), .key1_in(key1_in), .key2_in(key2_in), .key3_in(key3_in),
    .key0_out(key0_out), .key1_out(key1_out), .key2_out(key2_out), .key3_out(key3_out),
    .state_out(state_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [127:0] table_key(input int sel, input int r);
    return (sel != 0) ? KF[r] : KA[r];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [127:0] k, input logic [1:0] st, input logic [3:0] rnd);
    exp_t e;
    e.key = k;
    e.st  = st;
    e.rnd = rnd;
    sb.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_k0"}, key0_out, e.key[127:96]);
    check({tag, "_k1"}, key1_out, e.key[95:64]);
    check({tag, "_k2"}, key2_out, e.key[63:32]);
    check({tag, "_k3"}, key3_out, e.key[31:0]);
    check({tag, "_state"}, {30'd0, state_out}, {30'd0, e.st});
    check({tag, "_round"}, {28'd0, dut.round_r}, {28'd0, e.rnd});
  endtask

  task automatic drive_key(input logic [127:0] k);
    key0_in = k[127:96];
    key1_in = k[95:64];
    key2_in = k[63:32];
    key3_in = k[31:0];
  endtask

  // Load a key, expect rounds 0..10 plus hold cycles; optionally poke start mid-schedule.
  task automatic run_schedule(input int sel, input int n_hold, input bit poke);
    @(negedge CLK);
    start_in = 1'b1;
    drive_key(table_key(sel, 0));
    for (int r = 0; r <= 10; r++)
      push_exp(table_key(sel, r), (r == 10) ? 2'b10 : 2'b01, 4'(r));
    for (int h = 0; h < n_hold; h++)
      push_exp(table_key(sel, 10), 2'b10, 4'd10);
    for (int i = 0; i < 11 + n_hold; i++) begin
      @(posedge CLK);
      #1;
      compare_out($sformatf("s%0d_c%0d", sel, i));
      if (i == 0) begin
        start_in = 1'b0;
        drive_key({$urandom, $urandom, $urandom, $urandom});
      end
      if (poke && i == 4) begin
        start_in = 1'b1;
        drive_key(table_key(1 - sel, 0));
      end
      if (poke && i == 5) start_in = 1'b0;
    end
  endtask

  initial begin
    RST = 1'b1;
    start_in = 1'b0;
    drive_key(128'h0);
    #12;
    push_exp(128'h0, 2'b00, 4'd0);
    compare_out("reset");
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    push_exp(128'h0, 2'b00, 4'd0);
    compare_out("idle_hold");

    run_schedule(0, 5, 1'b0);
    run_schedule(0, 2, 1'b1);
    run_schedule(1, 2, 1'b0);

    // Async reset in the middle of a schedule
    @(negedge CLK);
    start_in = 1'b1;
    drive_key(KA[0]);
    @(posedge CLK);
    #1;
    start_in = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    push_exp(128'h0, 2'b00, 4'd0);
    compare_out("async_rst");
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    push_exp(128'h0, 2'b00, 4'd0);
    compare_out("post_rst_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
